multicycle_controller: RTL and testbench
========================================

MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 The block SHALL have these ports:
  clk  input  1  single clock, all state updates on rising edge.
  reset  input  1  asynchronous, active-high.
  Instr  input  20 [31:12]  instruction register bits: Cond[31:28], Op[27:26], Funct[25:20], Rd[15:12].
  ALUFlags  input  4  N,Z,C,V from ALU, current cycle.
  PCWrite  output  1  PC register load enable.
  MemWrite  output  1  data memory write enable.
  RegWrite  output  1  register file write enable.
  IRWrite  output  1  instruction register load enable.
  AdrSrc  output  1  0 = PC, 1 = ALUOut as memory address.
  RegSrc  output  2  register-read source selects.
  ALUSrcA  output  2  00 = RD1, 01 = PC.
  ALUSrcB  output  2  00 = RD2, 01 = ExtImm, 10 = constant 4.
  ResultSrc  output  2  00 = ALUOut, 01 = Data, 10 = ALUResult.
  ImmSrc  output  2  extend type, equals Op.
  ALUControl  output  2  00 ADD, 01 SUB, 10 AND, 11 ORR.

Function
REQ-002 The FSM SHALL use states FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECUTER, EXECUTEI, ALUWB, BRANCH.
REQ-003 Transitions SHALL be:
  - FETCH->DECODE.
  - DECODE: Op=01->MEMADR; Op=00 & Funct[5]=0->EXECUTER; Op=00 & Funct[5]=1->EXECUTEI; Op=10->BRANCH; Op=11->FETCH.
  - MEMADR: Funct[0]=1->MEMRD, else MEMWR.
  - MEMRD->MEMWB->FETCH; MEMWR->FETCH; EXECUTER/EXECUTEI->ALUWB->FETCH; BRANCH->FETCH.
REQ-004 Per-state outputs SHALL be as follows; unlisted outputs are 0 and ALUControl is ADD unless stated.
  - FETCH: AdrSrc=0, IRWrite=1, ALUSrcA=01, ALUSrcB=10, ResultSrc=10, PCWrite=1 unconditionally.
  - DECODE: ALUSrcA=01, ALUSrcB=10, ResultSrc=10.
  - MEMADR: ALUSrcA=00, ALUSrcB=01.
  - MEMRD: AdrSrc=1, ResultSrc=00.
  - MEMWB: ResultSrc=01, RegWrite=CondExReg.
  - MEMWR: AdrSrc=1, MemWrite=CondExReg.
  - EXECUTER: ALUSrcA=00, ALUSrcB=00, ALUControl=decoded.
  - EXECUTEI: ALUSrcA=00, ALUSrcB=01, ALUControl=decoded.
  - ALUWB: ResultSrc=00, RegWrite=CondExReg.
  - BRANCH: ALUSrcA=00, ALUSrcB=01, ResultSrc=10, PCWrite=CondExReg.
REQ-005 In MEMWB and ALUWB, Rd=1111 SHALL additionally assert PCWrite=CondExReg.
REQ-006 Decoded ALUControl from Funct[4:1]: 0100 ADD, 0010 SUB, 0000 AND, 1100 ORR; any other value -> ADD.
REQ-007 RegSrc[0]=1 when Op=10; RegSrc[1]=1 when Op=01 and Funct[0]=0; otherwise 0. ImmSrc SHALL equal Op in all states.
REQ-008 CondEx SHALL be the combinational evaluation of Cond against the stored Flags using the standard ARM codes 0000-1110; 1111 SHALL evaluate false.
REQ-009 CondExReg SHALL load CondEx on the rising edge that leaves DECODE and hold it until the next DECODE exit.
REQ-010 Flags[3:2] (N,Z) SHALL load ALUFlags[3:2] at the end of EXECUTER/EXECUTEI when Funct[0]=1 and CondExReg=1.
REQ-011 Flags[1:0] (C,V) SHALL load under the same condition only when the decoded op is ADD or SUB.
REQ-012 Instruction latency SHALL be: load 5 cycles, store 4, data-processing 4, branch 3, Op=11 2.

Reset
REQ-013 On reset assertion, regardless of clock: state=FETCH, Flags=0000, CondExReg=0.
REQ-014 While reset=1, PCWrite, IRWrite, RegWrite and MemWrite SHALL be 0.
REQ-015 Reset asserted mid-instruction SHALL abandon it with no further write enable asserted; FETCH SHALL execute on the first edge after deassertion.

Configuration
REQ-016 With MCCTRL_CMP_EN defined, Funct[4:1]=1010 SHALL decode as SUB with RegWrite forced 0 in ALUWB, and flags SHALL update per REQ-010/011 (CMP).
REQ-017 Without MCCTRL_CMP_EN, Funct[4:1]=1010 SHALL decode as ADD with a normal register write and C,V SHALL update as ADD.

Verification
REQ-018 The bench SHALL cover these scenarios:
  - Reset pulse mid-MEMRD -> state FETCH at once, all write enables 0, Flags=0000; first post-reset cycle IRWrite=1, PCWrite=1.
  - Instr=0xE590_1xxx (LDR, AL) -> states FETCH,DECODE,MEMADR,MEMRD,MEMWB; RegWrite=1 only in MEMWB with ResultSrc=01.
  - Instr=0xE04xxxxx (SUB register, no S) -> EXECUTER ALUControl=01, ALUWB RegWrite=1; Flags unchanged.
  - ADDS producing ALUFlags=0100, then Instr=0x0A...(BEQ) -> BRANCH with PCWrite=1; repeat with Z=0 -> PCWrite=0 in BRANCH.
  - Instr=0x1580_xxxx (STRNE) with Z=1 -> MEMWR MemWrite=0; with Z=0 -> MemWrite=1 and RegSrc=10.
  - CMP (0xE15xxxxx) under MCCTRL_CMP_EN -> ALUControl=01, RegWrite=0 in ALUWB, Flags loaded; without the macro -> ALUControl=00, RegWrite=1.

Source files
------------

// File: rtl/multicycle_controller.sv
`default_nettype none
// ============================================================================
// multicycle_controller : control FSM for an ARM-style multicycle processor.
// Optional feature macro: MCCTRL_CMP_EN (Funct[4:1]=1010 decodes as CMP).
// Revision: 1.0 - initial release
// ============================================================================
module multicycle_controller (
   input  logic         clk,
   input  logic         reset,
   input  logic [31:12] Instr,
   input  logic [3:0]   ALUFlags,
   output logic         PCWrite,
   output logic         MemWrite,
   output logic         RegWrite,
   output logic         IRWrite,
   output logic         AdrSrc,
   output logic [1:0]   RegSrc,
   output logic [1:0]   ALUSrcA,
   output logic [1:0]   ALUSrcB,
   output logic [1:0]   ResultSrc,
   output logic [1:0]   ImmSrc,
   output logic [1:0]   ALUControl
);

   typedef enum logic [3:0] {
      FETCH    = 4'd0,
      DECODE   = 4'd1,
      MEMADR   = 4'd2,
      MEMRD    = 4'd3,
      MEMWB    = 4'd4,
      MEMWR    = 4'd5,
      EXECUTER = 4'd6,
      EXECUTEI = 4'd7,
      ALUWB    = 4'd8,
      BRANCH   = 4'd9
   } state_t;

   state_t     state_q, state_d;
   logic [3:0] flags_q, flags_d;
   logic       condex_q, condex_d;

   logic [3:0] cond;
   logic [1:0] op;
   logic [5:0] funct;
   logic [3:0] rd;
   logic       unused_rn;

   assign cond      = Instr[31:28];
   assign op        = Instr[27:26];
   assign funct     = Instr[25:20];
   assign rd        = Instr[15:12];
   assign unused_rn = ^Instr[19:16];

   // Condition evaluation against the stored N,Z,C,V
   logic condex;
   logic n_f, z_f, c_f, v_f;
   assign {n_f, z_f, c_f, v_f} = flags_q;

   always_comb begin
      condex = 1'b0;
      case (cond)
         4'b0000: condex = z_f;
         4'b0001: condex = ~z_f;
         4'b0010: condex = c_f;
         4'b0011: condex = ~c_f;
         4'b0100: condex = n_f;
         4'b0101: condex = ~n_f;
         4'b0110: condex = v_f;
         4'b0111: condex = ~v_f;
         4'b1000: condex = c_f & ~z_f;
         4'b1001: condex = ~c_f | z_f;
         4'b1010: condex = (n_f == v_f);
         4'b1011: condex = (n_f != v_f);
         4'b1100: condex = ~z_f & (n_f == v_f);
         4'b1101: condex = z_f | (n_f != v_f);
         4'b1110: condex = 1'b1;
         default: condex = 1'b0;
      endcase
   end

   logic [1:0] alu_dec;
   logic       is_cmp;

   always_comb begin
      alu_dec = 2'b00;
      is_cmp  = 1'b0;
      case (funct[4:1])
         4'b0100: alu_dec = 2'b00;
         4'b0010: alu_dec = 2'b01;
         4'b0000: alu_dec = 2'b10;
         4'b1100: alu_dec = 2'b11;
`ifdef MCCTRL_CMP_EN
         4'b1010: begin
            alu_dec = 2'b01;
            is_cmp  = 1'b1;
         end
`else
         4'b1010: alu_dec = 2'b00;
`endif
         default: alu_dec = 2'b00;
      endcase
   end

   logic pc_write, mem_write, reg_write, ir_write;

   always_comb begin
      state_d    = state_q;
      flags_d    = flags_q;
      condex_d   = condex_q;
      pc_write   = 1'b0;
      mem_write  = 1'b0;
      reg_write  = 1'b0;
      ir_write   = 1'b0;
      AdrSrc     = 1'b0;
      ALUSrcA    = 2'b00;
      ALUSrcB    = 2'b00;
      ResultSrc  = 2'b00;
      ALUControl = 2'b00;
      case (state_q)
         FETCH: begin
            ir_write  = 1'b1;
            pc_write  = 1'b1;
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            state_d   = DECODE;
         end
         DECODE: begin
            ALUSrcA   = 2'b01;
            ALUSrcB   = 2'b10;
            ResultSrc = 2'b10;
            condex_d  = condex;
            case (op)
               2'b01:   state_d = MEMADR;
               2'b00:   state_d = funct[5] ? EXECUTEI : EXECUTER;
               2'b10:   state_d = BRANCH;
               default: state_d = FETCH;
            endcase
         end
         MEMADR: begin
            ALUSrcB = 2'b01;
            state_d = funct[0] ? MEMRD : MEMWR;
         end
         MEMRD: begin
            AdrSrc  = 1'b1;
            state_d = MEMWB;
         end
         MEMWB: begin
            ResultSrc = 2'b01;
            reg_write = condex_q;
            pc_write  = (rd == 4'hF) & condex_q;
            state_d   = FETCH;
         end
         MEMWR: begin
            AdrSrc    = 1'b1;
            mem_write = condex_q;
            state_d   = FETCH;
         end
         EXECUTER, EXECUTEI: begin
            ALUSrcB    = (state_q == EXECUTEI) ? 2'b01 : 2'b00;
            ALUControl = alu_dec;
            // N,Z follow any flag-setting op; C,V only arithmetic ones
            if (funct[0] && condex_q) begin
               flags_d[3:2] = ALUFlags[3:2];
               if (!alu_dec[1])
                  flags_d[1:0] = ALUFlags[1:0];
            end
            state_d = ALUWB;
         end
         ALUWB: begin
            reg_write = condex_q & ~is_cmp;
            pc_write  = (rd == 4'hF) & condex_q;
            state_d   = FETCH;
         end
         BRANCH: begin
            ALUSrcB   = 2'b01;
            ResultSrc = 2'b10;
            pc_write  = condex_q;
            state_d   = FETCH;
         end
         default: state_d = FETCH;
      endcase
   end

   // Write enables are squashed for the whole time reset is high
   assign PCWrite  = pc_write  & ~reset;
   assign MemWrite = mem_write & ~reset;
   assign RegWrite = reg_write & ~reset;
   assign IRWrite  = ir_write  & ~reset;

   assign RegSrc = {(op == 2'b01) & ~funct[0], (op == 2'b10)};
   assign ImmSrc = op;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state_q  <= FETCH;
         flags_q  <= 4'b0000;
         condex_q <= 1'b0;
      end else begin
         state_q  <= state_d;
         flags_q  <= flags_d;
         condex_q <= condex_d;
      end
   end

endmodule
`default_nettype wire

// File: tb/tb_multicycle_controller.sv
`default_nettype none
// ============================================================================
// tb_multicycle_controller : scoreboard bench for the multicycle controller.
// Revision: 1.0 - initial release
// ============================================================================
module tb_multicycle_controller;

   logic         clk = 1'b0;
   logic         reset;
   logic [31:12] Instr;
   logic [3:0]   ALUFlags;
   logic         PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc;
   logic [1:0]   RegSrc, ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl;

   multicycle_controller dut (
      .clk       (clk),
      .reset     (reset),
      .Instr     (Instr),
      .ALUFlags  (ALUFlags),
      .PCWrite   (PCWrite),
      .MemWrite  (MemWrite),
      .RegWrite  (RegWrite),
      .IRWrite   (IRWrite),
      .AdrSrc    (AdrSrc),
      .RegSrc    (RegSrc),
      .ALUSrcA   (ALUSrcA),
      .ALUSrcB   (ALUSrcB),
      .ResultSrc (ResultSrc),
      .ImmSrc    (ImmSrc),
      .ALUControl(ALUControl)
   );

   always #5 clk = ~clk;

   typedef enum int {
      T_FETCH, T_DECODE, T_MEMADR, T_MEMRD, T_MEMWB,
      T_MEMWR, T_EXECR, T_EXECI, T_ALUWB, T_BRANCH
   } tstate_t;

   localparam logic [16:0] WE_MASK = 17'h1E000;

   int          checks   = 0;
   int          failures = 0;
   string       tag_q[$];
   logic [16:0] word_q[$];
   logic [3:0]  m_flags = 4'b0000;
   logic        m_cx    = 1'b0;
   logic [16:0] obs_word;

   assign obs_word = {PCWrite, MemWrite, RegWrite, IRWrite, AdrSrc, RegSrc,
                      ALUSrcA, ALUSrcB, ResultSrc, ImmSrc, ALUControl};

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         failures++;
         $display("FAIL %s: observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   function automatic logic m_cond(input logic [3:0] c, input logic [3:0] f);
      logic n, z, cy, v;
      {n, z, cy, v} = f;
      case (c)
         4'h0: return z;
         4'h1: return !z;
         4'h2: return cy;
         4'h3: return !cy;
         4'h4: return n;
         4'h5: return !n;
         4'h6: return v;
         4'h7: return !v;
         4'h8: return cy && !z;
         4'h9: return !cy || z;
         4'hA: return n == v;
         4'hB: return n != v;
         4'hC: return !z && (n == v);
         4'hD: return z || (n != v);
         4'hE: return 1'b1;
         default: return 1'b0;
      endcase
   endfunction

   function automatic logic [1:0] m_alu(input logic [5:0] f);
      case (f[4:1])
         4'b0010: return 2'b01;
         4'b0000: return 2'b10;
         4'b1100: return 2'b11;
`ifdef MCCTRL_CMP_EN
         4'b1010: return 2'b01;
`endif
         default: return 2'b00;
      endcase
   endfunction

   function automatic logic m_is_cmp(input logic [5:0] f);
`ifdef MCCTRL_CMP_EN
      return f[4:1] == 4'b1010;
`else
      return (f[4:1] == 4'b1010) && 1'b0;
`endif
   endfunction

   function automatic logic [16:0] exp_word(input tstate_t s, input logic [19:0] ins, input logic cx);
      logic [1:0] op, rs, sa, sb, res, alu;
      logic [5:0] fn;
      logic       pw, mw, rw, iw, as, pc_rd;
      op = ins[15:14];
      fn = ins[13:8];
      pc_rd = (ins[3:0] == 4'hF);
      {pw, mw, rw, iw, as} = 5'b0;
      {sa, sb, res, alu} = 8'b0;
      rs = {(op == 2'b01) && !fn[0], op == 2'b10};
      case (s)
         T_FETCH:  begin iw = 1; pw = 1; sa = 2'b01; sb = 2'b10; res = 2'b10; end
         T_DECODE: begin sa = 2'b01; sb = 2'b10; res = 2'b10; end
         T_MEMADR: sb = 2'b01;
         T_MEMRD:  as = 1;
         T_MEMWB:  begin res = 2'b01; rw = cx; pw = cx && pc_rd; end
         T_MEMWR:  begin as = 1; mw = cx; end
         T_EXECR:  alu = m_alu(fn);
         T_EXECI:  begin sb = 2'b01; alu = m_alu(fn); end
         T_ALUWB:  begin rw = cx && !m_is_cmp(fn); pw = cx && pc_rd; end
         default:  begin sb = 2'b01; res = 2'b10; pw = cx; end
      endcase
      return {pw, mw, rw, iw, as, rs, sa, sb, res, op, alu};
   endfunction

   // Expects to be entered shortly after a rising edge with the DUT in FETCH
   task automatic run_instr(input string name, input logic [19:0] ins, input logic [3:0] af);
      tstate_t    seq[$];
      logic [5:0] fn;
      int         n;
      fn  = ins[13:8];
      seq = {T_FETCH, T_DECODE};
      case (ins[15:14])
         2'b01: begin
            seq.push_back(T_MEMADR);
            if (fn[0]) begin seq.push_back(T_MEMRD); seq.push_back(T_MEMWB); end
            else seq.push_back(T_MEMWR);
         end
         2'b00: begin
            seq.push_back(fn[5] ? T_EXECI : T_EXECR);
            seq.push_back(T_ALUWB);
         end
         2'b10: seq.push_back(T_BRANCH);
         default: ;
      endcase
      foreach (seq[i]) begin
         if (seq[i] == T_MEMADR || seq[i] == T_EXECR || seq[i] == T_EXECI || seq[i] == T_BRANCH)
            m_cx = m_cond(ins[19:16], m_flags);
         tag_q.push_back($sformatf("%s/%s", name, seq[i].name()));
         word_q.push_back(exp_word(seq[i], ins, m_cx));
      end
      if (ins[15:14] == 2'b00 && fn[0] && m_cx) begin
         m_flags[3:2] = af[3:2];
         if (m_alu(fn) inside {2'b00, 2'b01}) m_flags[1:0] = af[1:0];
      end
      n = seq.size();
      Instr    = ins;
      ALUFlags = af;
      for (int k = 0; k < n; k++) begin
         @(negedge clk);
         check(tag_q.pop_front(), {15'b0, obs_word}, {15'b0, word_q.pop_front()});
         @(posedge clk);
         #1;
      end
   endtask

   initial begin
      logic [19:0] ldr;
      reset    = 1'b0;
      Instr    = 20'h0;
      ALUFlags = 4'h0;
      #2 reset = 1'b1;
      #1 check("reset_state", {15'b0, obs_word}, {15'b0, exp_word(T_FETCH, 20'h0, 1'b0) & ~WE_MASK});
      @(posedge clk);
      @(posedge clk);
      #1 reset = 1'b0;

      run_instr("ldr",       20'hE5901, 4'h0);
      run_instr("sub",       20'hE0412, 4'hF);
      run_instr("adds_z1",   20'hE0913, 4'b0100);
      run_instr("beq_t",     20'h0A000, 4'h0);
      run_instr("adds_z0",   20'hE0913, 4'b0000);
      run_instr("beq_nt",    20'h0A000, 4'h0);
      run_instr("adds_z1b",  20'hE0913, 4'b0100);
      run_instr("strne_nx",  20'h15800, 4'h0);
      run_instr("adds_z0b",  20'hE0913, 4'b0000);
      run_instr("strne_x",   20'h15800, 4'h0);
      run_instr("cmp",       20'hE1500, 4'b0110);
      run_instr("beq_cmp",   20'h0A000, 4'h0);
      run_instr("adds_c1",   20'hE0913, 4'b0010);
      run_instr("orrs",      20'hE1914, 4'b1001);
      run_instr("bcs_keep",  20'h2A000, 4'h0);
      run_instr("bvs_keep",  20'h6A000, 4'h0);
      run_instr("bmi_set",   20'h4A000, 4'h0);
      run_instr("and",       20'hE0010, 4'h0);
      run_instr("addi_pc",   20'hE28FF, 4'h0);
      run_instr("addseq_nx", 20'h00913, 4'b0100);
      run_instr("beq_nx",    20'h0A000, 4'h0);
      run_instr("op11",      20'hEC000, 4'h0);
      run_instr("bnv",       20'hFA000, 4'h0);
      run_instr("ldr_pc",    20'hE591F, 4'h0);
      run_instr("adds_all",  20'hE0913, 4'b1111);

      // Abandon a load in MEMRD with an asynchronous reset pulse
      ldr      = 20'hE5901;
      Instr    = ldr;
      ALUFlags = 4'h0;
      for (int k = 0; k < 3; k++) begin
         @(posedge clk);
         #1;
      end
      m_cx = m_cond(ldr[19:16], m_flags);
      @(negedge clk);
      check("rst_pre_memrd", {15'b0, obs_word}, {15'b0, exp_word(T_MEMRD, ldr, m_cx)});
      #2 reset = 1'b1;
      m_flags = 4'b0000;
      m_cx    = 1'b0;
      #1 check("rst_async", {15'b0, obs_word}, {15'b0, exp_word(T_FETCH, ldr, 1'b0) & ~WE_MASK});
      @(posedge clk);
      #1 check("rst_hold", {15'b0, obs_word}, {15'b0, exp_word(T_FETCH, ldr, 1'b0) & ~WE_MASK});
      reset = 1'b0;
      #1 check("rst_release", {15'b0, obs_word}, {15'b0, exp_word(T_FETCH, ldr, 1'b0)});

      run_instr("bmi_rst",   20'h4A000, 4'h0);
      run_instr("bcs_rst",   20'h2A000, 4'h0);
      run_instr("bvs_rst",   20'h6A000, 4'h0);
      run_instr("ldr_rst",   20'hE5901, 4'h0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
